// File: rtl/retospect_bs_loader.sv
// Byte-wide loader that serialises configuration bytes LSB-first onto the neurochip chain.
// Optional CRC-8 trailer check is enabled by defining RETOSPECT_BS_CRC_EN.
module retospect_bs_loader #(
  parameter int CHAIN_LEN = 523,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       config_en,
  output logic       bs_out,
  output logic       reset_nn,
  output logic       busy,
  output logic       done,
  output logic       error
);

`ifdef RETOSPECT_BS_CRC_EN
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, CHECK, PULSE} state_t;
`else
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, PULSE} state_t;
`endif

  localparam int EXT_W = CNT_W + 4;
  localparam logic [CNT_W-1:0] CHAIN_LEN_C = CNT_W'(CHAIN_LEN);

  state_t           state_q, state_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [3:0]       left_q, left_d;
  logic [CNT_W-1:0] bits_done_q, bits_done_d;
  logic             byte_ready_q, byte_ready_d;
  logic             config_en_q, config_en_d;
  logic             bs_out_q, bs_out_d;
  logic             reset_nn_q, reset_nn_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [EXT_W-1:0] rem_ext;
  logic [3:0]       nbits;

  // Widened so the compare against 8 stays exact even for very short chains.
  assign rem_ext = {4'b0000, CHAIN_LEN_C - bits_done_q};
  assign nbits   = (rem_ext >= EXT_W'(8)) ? 4'd8 : rem_ext[3:0];

`ifdef RETOSPECT_BS_CRC_EN
  logic [7:0] crc_q, crc_d;
  logic       error_q, error_d;

  function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
    logic fb;
    fb = c[7] ^ b;
    return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  endfunction
`endif

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    left_d      = left_q;
    bits_done_d = bits_done_q;
    bs_out_d    = 1'b0;
`ifdef RETOSPECT_BS_CRC_EN
    crc_d       = crc_q;
    error_d     = error_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          bits_done_d = '0;
`ifdef RETOSPECT_BS_CRC_EN
          crc_d       = 8'h00;
          error_d     = 1'b0;
`endif
          state_d     = LOAD;
        end
      end
      LOAD: begin
        if (byte_valid) begin
          shreg_d  = {1'b0, byte_in[7:1]};
          bs_out_d = byte_in[0];
          left_d   = nbits;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        // The bit on bs_out this cycle is the one being counted and hashed.
        bits_done_d = bits_done_q + 1'b1;
        left_d      = left_q - 4'd1;
`ifdef RETOSPECT_BS_CRC_EN
        crc_d       = crc_step(crc_q, bs_out_q);
`endif
        if (left_q == 4'd1) begin
          if (bits_done_d == CHAIN_LEN_C) begin
`ifdef RETOSPECT_BS_CRC_EN
            state_d = CHECK;
`else
            state_d = PULSE;
`endif
          end else begin
            state_d = LOAD;
          end
        end else begin
          bs_out_d = shreg_q[0];
          shreg_d  = {1'b0, shreg_q[7:1]};
        end
      end
`ifdef RETOSPECT_BS_CRC_EN
      CHECK: begin
        if (byte_valid) begin
          if (byte_in == crc_q) begin
            state_d = PULSE;
          end else begin
            error_d = 1'b1;
            state_d = IDLE;
          end
        end
      end
`endif
      PULSE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they can be registered.
`ifdef RETOSPECT_BS_CRC_EN
    byte_ready_d = (state_d == LOAD) || (state_d == CHECK);
`else
    byte_ready_d = (state_d == LOAD);
`endif
    config_en_d = (state_d == SHIFT);
    busy_d      = (state_d != IDLE);
    reset_nn_d  = (state_d == PULSE);
    done_d      = (state_d == PULSE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      shreg_q      <= 8'h00;
      left_q       <= 4'd0;
      bits_done_q  <= '0;
      byte_ready_q <= 1'b0;
      config_en_q  <= 1'b0;
      bs_out_q     <= 1'b0;
      reset_nn_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef RETOSPECT_BS_CRC_EN
      crc_q        <= 8'h00;
      error_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      left_q       <= left_d;
      bits_done_q  <= bits_done_d;
      byte_ready_q <= byte_ready_d;
      config_en_q  <= config_en_d;
      bs_out_q     <= bs_out_d;
      reset_nn_q   <= reset_nn_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
`ifdef RETOSPECT_BS_CRC_EN
      crc_q        <= crc_d;
      error_q      <= error_d;
`endif
    end
  end

  assign byte_ready = byte_ready_q;
  assign config_en  = config_en_q;
  assign bs_out     = bs_out_q;
  assign reset_nn   = reset_nn_q;
  assign busy       = busy_q;
  assign done       = done_q;
`ifdef RETOSPECT_BS_CRC_EN
  assign error      = error_q;
`else
  assign error      = 1'b0;
`endif

endmodule

// File: tb/tb_retospect_bs_loader.sv
// Randomised bench for retospect_bs_loader: expected chain bitstream, byte framing and
// CRC trailer are derived from the byte list; works with or without RETOSPECT_BS_CRC_EN.
module tb_retospect_bs_loader;

  localparam int CL     = 523;
  localparam int NBYTES = (CL + 7) / 8;
  localparam int LIMIT  = 3000;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;
  logic       config_en;
  logic       bs_out;
  logic       reset_nn;
  logic       busy;
  logic       done;
  logic       error;

  always #5 clk = ~clk;

  retospect_bs_loader #(.CHAIN_LEN(CL)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .config_en  (config_en),
    .bs_out     (bs_out),
    .reset_nn   (reset_nn),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] data [NBYTES];

  bit mon_on = 0;
  bit cap_q[$];
  int runs_q[$];
  int run_len, rnn_cnt, done_cnt, rdy_pulses;
  bit prev_cen, prev_rdy, prev_rnn;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    cap_q.delete();
    runs_q.delete();
    run_len    = 0;
    rnn_cnt    = 0;
    done_cnt   = 0;
    rdy_pulses = 0;
    prev_cen   = 0;
    prev_rdy   = 0;
    prev_rnn   = 0;
  endtask

  // Per-cycle observation of the chain side, sampled at the falling edge.
  task automatic sample();
    if (config_en) begin
      cap_q.push_back(bs_out);
      run_len++;
      checkOutput("ready_during_shift", byte_ready, 0);
    end else if (prev_cen) begin
      runs_q.push_back(run_len);
      run_len = 0;
`ifdef RETOSPECT_BS_CRC_EN
      checkOutput("ready_after_run", byte_ready, 1);
`else
      checkOutput("pulse_after_last_run", reset_nn, runs_q.size() == NBYTES);
      checkOutput("ready_after_run", byte_ready, runs_q.size() != NBYTES);
`endif
    end
    if (prev_rnn) checkOutput("busy_low_after_pulse", busy, 0);
    if (byte_ready && !prev_rdy) rdy_pulses++;
    if (reset_nn) rnn_cnt++;
    if (done) done_cnt++;
`ifndef RETOSPECT_BS_CRC_EN
    checkOutput("error_tied_low", error, 0);
`endif
    prev_cen = config_en;
    prev_rdy = byte_ready;
    prev_rnn = reset_nn;
  endtask

  task automatic tick();
    @(negedge clk);
    if (mon_on) sample();
  endtask

  function automatic bit exp_bit(input int b);
    logic [7:0] v;
    v = data[b / 8];
    return v[b % 8];
  endfunction

  function automatic logic [7:0] model_crc();
    logic [7:0] c;
    bit fb;
    c = 8'h00;
    for (int b = 0; b < CL; b++) begin
      fb = c[7] ^ exp_bit(b);
      c  = {c[6:0], 1'b0};
      if (fb) c = c ^ 8'h07;
    end
    return c;
  endfunction

  // One complete load: fill mode 0 = all 0xFF, 1 = random bytes.
  task automatic applyStimulus(input int fill, input int stall_max, input bit glitch, input bit crc_good);
    int idx, stall, cyc, total, bad_bits, bad_runs, exp_last;
    logic [7:0] crc_byte;
    for (int i = 0; i < NBYTES; i++) data[i] = (fill == 0) ? 8'hFF : 8'($urandom);
    crc_byte = crc_good ? model_crc() : (model_crc() ^ 8'h01);
`ifdef RETOSPECT_BS_CRC_EN
    total = NBYTES + 1;
`else
    total = NBYTES;
`endif
    clear_mon();
    mon_on = 1;
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("busy_after_start", busy, 1);
    checkOutput("ready_after_start", byte_ready, 1);
    checkOutput("error_clear_after_start", error, 0);
    idx = 0;
    stall = 0;
    cyc = 0;
    while (busy === 1'b1 && cyc < LIMIT) begin
      start = glitch && ($urandom_range(0, 7) == 0);
      if (byte_ready && stall > 0) begin
        byte_valid = 1'b0;
        byte_in    = 8'($urandom);
        stall--;
      end else if (idx < total) begin
        byte_valid = 1'b1;
        byte_in    = (idx < NBYTES) ? data[idx] : crc_byte;
        if (byte_ready) begin
          idx++;
          stall = $urandom_range(0, stall_max);
        end
      end else begin
        byte_valid = 1'b0;
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    byte_valid = 1'b0;
    checkOutput("load_within_budget", cyc < LIMIT, 1);

    bad_bits = 0;
    for (int b = 0; b < cap_q.size() && b < CL; b++) if (cap_q[b] != exp_bit(b)) bad_bits++;
    exp_last = CL - 8 * (NBYTES - 1);
    bad_runs = 0;
    for (int r = 0; r < runs_q.size(); r++)
      if (runs_q[r] != ((r == NBYTES - 1) ? exp_last : 8)) bad_runs++;

    checkOutput("config_en_cycles", cap_q.size(), CL);
    checkOutput("bitstream_errors", bad_bits, 0);
    checkOutput("shift_run_count", runs_q.size(), NBYTES);
    checkOutput("shift_run_len_errors", bad_runs, 0);
    checkOutput("ready_pulses", rdy_pulses, total);
`ifdef RETOSPECT_BS_CRC_EN
    checkOutput("reset_nn_pulses", rnn_cnt, crc_good ? 1 : 0);
    checkOutput("done_pulses", done_cnt, crc_good ? 1 : 0);
    checkOutput("error_flag", error, crc_good ? 0 : 1);
`else
    checkOutput("reset_nn_pulses", rnn_cnt, 1);
    checkOutput("done_pulses", done_cnt, 1);
    checkOutput("error_flag", error, 0);
`endif
    mon_on = 0;
  endtask

  initial begin
    int n;
    reset      = 1'b1;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_in    = 8'h00;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    checkOutput("rst_byte_ready", byte_ready, 0);
    checkOutput("rst_config_en", config_en, 0);
    checkOutput("rst_bs_out", bs_out, 0);
    checkOutput("rst_reset_nn", reset_nn, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_error", error, 0);

    $display("[TB] load of 0xFF bytes with byte_valid held high");
    applyStimulus(0, 0, 0, 1);
    $display("[TB] random load with 5-cycle stalls and stray start pulses");
    applyStimulus(1, 5, 1, 1);
    $display("[TB] random load with short random stalls");
    applyStimulus(1, 2, 0, 1);

    $display("[TB] reset during the 4th shift cycle");
    start = 1'b1;
    tick();
    start = 1'b0;
    byte_valid = 1'b1;
    byte_in = 8'($urandom);
    n = 0;
    for (int c = 0; c < 50 && n < 4; c++) begin
      tick();
      if (config_en) n++;
    end
    checkOutput("reached_4th_shift", n, 4);
    byte_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("mid_reset_config_en", config_en, 0);
    checkOutput("mid_reset_busy", busy, 0);
    checkOutput("mid_reset_ready", byte_ready, 0);
    applyStimulus(1, 1, 0, 1);

`ifdef RETOSPECT_BS_CRC_EN
    $display("[TB] wrong CRC trailer, then a clean reload");
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 1, 0, 1);
`endif

    $display("[TB] stray byte offered while idle");
    byte_valid = 1'b1;
    byte_in = 8'h5A;
    for (int c = 0; c < 4; c++) begin
      tick();
      checkOutput("idle_ready_low", byte_ready, 0);
      checkOutput("idle_config_en_low", config_en, 0);
    end
    byte_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/retospect_bs_loader.md
# retospect_bs_loader

Byte-wide configuration loader that sits directly upstream of the neurochip configuration chain. It accepts configuration bytes over a valid/ready handshake and serialises them LSB-first onto the chain's `bs_in`, asserting `config_en` for exactly one cycle per chain bit. After the last bit it issues a one-cycle `reset_nn` pulse to re-initialise neuron potentials and clock counters. The host therefore never has to bit-bang `config_en` or `bs_in`.

## Interface
Parameters:
- `CHAIN_LEN`, default 523: total chain bits; 6×8 clockbox bits plus 25 cells × 19 bits.
- `CNT_W`, default `$clog2(CHAIN_LEN+1)`: width of the bit counter.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high; all registers go to their reset values.
- `start`  in  1  begins a load when sampled high in IDLE; ignored otherwise.
- `byte_in`  in  8  configuration byte.
- `byte_valid`  in  1  `byte_in` is valid.
- `byte_ready`  out  1  loader can accept a byte; a transfer occurs on `byte_valid & byte_ready`.
- `config_en`  out  1  drives the chain's `config_en`.
- `bs_out`  out  1  drives the chain's `bs_in`.
- `reset_nn`  out  1  one-cycle post-load initialisation pulse.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse on successful completion.
- `error`  out  1  sticky CRC mismatch flag (see Configuration).

## Operation
- States: IDLE, LOAD, SHIFT, CHECK (only with CRC), PULSE.
- **IDLE:** `start`=1 clears the bit counter and the `error` flag, then goes to LOAD.
- **LOAD:** `byte_ready`=1. On transfer, latch the byte into an 8-bit shift register, set `nbits = min(8, CHAIN_LEN − bits_done)`, and go to SHIFT.
- **SHIFT:** each cycle drives `config_en`=1 and `bs_out` = shreg[0], then shifts shreg right and increments `bits_done`.
  - After `nbits` cycles: if `bits_done == CHAIN_LEN`, go to CHECK (CRC build) or PULSE. Otherwise go to LOAD.
  - When the final byte is partial, its upper `8−nbits` bits are discarded. For example, with 523 bits, only bits [2:0] of byte 66 are shifted.
- **CHECK:** `byte_ready`=1. On transfer, compare the byte with the running CRC. A match goes to PULSE. A mismatch sets `error` and goes to IDLE without pulsing `reset_nn` or `done`.
- **PULSE:** `reset_nn`=1 and `done`=1 for one cycle, then go to IDLE.
- `config_en` is 0 in every state except SHIFT, so the chain shifts exactly `CHAIN_LEN` times per load.
- `byte_valid` while `byte_ready`=0 is ignored; the host must hold the byte. `byte_in` is don't-care when `byte_valid`=0.
- `start` while busy is ignored. There is no abort; `reset` is the only way out of a load.

## Timing
- All outputs are registered. Reset values: `byte_ready`, `config_en`, `bs_out`, `reset_nn`, `busy`, `done`, `error` are all 0; state = IDLE; counters and CRC = 0.
- `start` sampled at edge t: `busy` and `byte_ready` are high from cycle t+1.
- Byte accepted at edge k:
  - `config_en`=1 during cycles k+1..k+nbits, with `bs_out` = byte[i] in cycle k+1+i.
  - `byte_ready` is high again in cycle k+nbits+1.
  - Full bytes therefore take 9 cycles each, with no overlap.
- Last chain bit in cycle m:
  - Without CRC: `reset_nn`/`done` high in cycle m+1, `busy` low from m+2.
  - With CRC: `byte_ready` high from m+1; the CRC byte accepted at edge c gives PULSE in cycle c+1, or `error`=1 from c+1.
- `reset` asserted mid-load: `config_en` and `busy` are 0 in the very next cycle. The chain contents are left partially shifted, and the host must reload.
- Bit counter: `bits_done` never exceeds `CHAIN_LEN`. The comparison is done at `CNT_W` width with no wrap.

## Configuration
- Macro `RETOSPECT_BS_CRC_EN`.
- Defined:
  - A CRC-8 (poly 0x07, init 0x00, MSB-first register) is updated on every shifted bit. Per bit: `fb = crc[7] ^ bs_out`, then `crc = {crc[6:0],1'b0} ^ (fb ? 8'h07 : 8'h00)`.
  - Discarded pad bits are not included in the CRC.
  - The CHECK state is present, and one extra byte carrying the CRC is required after the data bytes.
- Undefined: CHECK state and CRC logic are absent, SHIFT completion goes straight to PULSE, and `error` is tied to 0.

## Test plan
- `CHAIN_LEN`=8, byte 0xA5 with `byte_valid` held high → `config_en` high exactly 8 cycles, `bs_out` sequence 1,0,1,0,0,1,0,1, then one `reset_nn`/`done` pulse.
- `CHAIN_LEN`=523, 66 bytes of 0xFF → exactly 523 `config_en` cycles, last byte shifts 3 bits, `byte_ready` pulses 66 times.
- Handshake: deassert `byte_valid` for 5 cycles between bytes → `config_en` stays 0 during the stall and the bit order is unchanged. `start` pulsed mid-load → no effect.
- `reset` asserted in the 4th SHIFT cycle → next cycle `config_en`=0, `busy`=0. A fresh `start` then loads all `CHAIN_LEN` bits normally.
- CRC build, `CHAIN_LEN`=8, data 0x01, CRC byte 0x89 → `done` pulse, `error`=0. Same data with CRC byte 0x88 → `error`=1, no `reset_nn` pulse, `error` cleared by the next `start`.
- Non-CRC build → `error` constant 0, and a stray byte offered after completion is not accepted (`byte_ready`=0 in IDLE).
